// File: rtl/keypad_operand_ctrl.sv
// -----------------------------------------------------------------------------
// keypad_operand_ctrl
//
// Purpose:
//   Takes debounced key captures from the keypad reader and assembles two
//   decimal operands, A then B. The finished pair is presented to the
//   adder/7-segment stage. This block is the only driver of the reader's ack.
//
//   Key map ({key_col,key_row}, bit3 = column/row 0):
//     columns 0..2 x rows 0..2 -> digits 1..9, row-major
//     column 1, row 3 -> 0
//     column 0, row 3 -> '*' (clear)
//     column 2, row 3 -> '#' (finish operand)
//   Any other pattern is rejected with a key_err pulse.
//
// Optional feature (compile-time macro INPUT_TIMEOUT_EN):
//   If the macro is defined, a partially entered pair is cleared automatically
//   after TIMEOUT_CYCLES idle cycles, and timeout pulses for one cycle.
//   If it is undefined, no counter exists and timeout is tied low.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   key_col      one-hot column of the captured key
//   key_row      one-hot row of the captured key
//   key_valid    capture available from the reader
//   key_ack      one-cycle pulse that consumes the capture
//   operand_a    binary value of operand A
//   operand_b    binary value of operand B
//   digit_count  digits entered in the current operand
//   entering_b   0 = A being entered, 1 = B being entered
//   ops_valid    operand pair complete and held stable
//   ops_ack      downstream consumed the pair
//   key_err      one-cycle pulse: key rejected
//   timeout      one-cycle pulse: auto-clear fired
// -----------------------------------------------------------------------------
module keypad_operand_ctrl #(
    parameter int WIDTH          = 4,
    parameter int MAX_DIGITS     = 3,
    parameter int OP_W           = 10,
    parameter int TIMEOUT_CYCLES = 27000000
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [WIDTH-1:0]                  key_col,
    input  logic [WIDTH-1:0]                  key_row,
    input  logic                              key_valid,
    output logic                              key_ack,
    output logic [OP_W-1:0]                   operand_a,
    output logic [OP_W-1:0]                   operand_b,
    output logic [$clog2(MAX_DIGITS+1)-1:0]   digit_count,
    output logic                              entering_b,
    output logic                              ops_valid,
    input  logic                              ops_ack,
    output logic                              key_err,
    output logic                              timeout
);

    localparam int DC_W = $clog2(MAX_DIGITS+1);

    localparam logic [1:0] ST_ENTER_A = 2'd0;
    localparam logic [1:0] ST_ENTER_B = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;

    localparam logic [1:0] KIND_INVALID = 2'd0;
    localparam logic [1:0] KIND_DIGIT   = 2'd1;
    localparam logic [1:0] KIND_STAR    = 2'd2;
    localparam logic [1:0] KIND_HASH    = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [OP_W-1:0] operand_a_q, operand_a_d;
    logic [OP_W-1:0] operand_b_q, operand_b_d;
    logic [DC_W-1:0] digit_count_q, digit_count_d;
    logic            key_ack_q, key_ack_d;
    logic            key_err_q, key_err_d;

    logic            accept;
    logic            clear_req;
    logic [1:0]      key_kind;
    logic [3:0]      key_digit;
    int              col_idx;
    int              row_idx;

`ifdef INPUT_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TO_W-1:0] idle_cnt_q, idle_cnt_d;
    logic            timeout_q, timeout_d;
`endif

    // A new capture is only taken while no ack is outstanding; the reader
    // drops valid right after the ack, so a key can never be taken twice.
    assign accept = key_valid && !key_ack_q;

    // Multiply-by-ten as shift-and-add, then append the new digit.
    function automatic logic [OP_W-1:0] append_digit(input logic [OP_W-1:0] x,
                                                     input logic [3:0]      d);
        return (x << 3) + (x << 1) + OP_W'(d);
    endfunction

    // Convert the one-hot column/row into indices (MSB is index 0) and
    // classify the key. Anything that is not one-hot in both is invalid.
    always_comb begin
        col_idx   = 0;
        row_idx   = 0;
        key_kind  = KIND_INVALID;
        key_digit = 4'd0;
        for (int i = 0; i < WIDTH; i++) begin
            if (key_col[WIDTH-1-i]) col_idx = i;
            if (key_row[WIDTH-1-i]) row_idx = i;
        end
        if ($onehot(key_col) && $onehot(key_row)) begin
            if (col_idx < 3 && row_idx < 3) begin
                key_kind  = KIND_DIGIT;
                key_digit = 4'(row_idx * 3 + col_idx + 1);
            end else if (row_idx == 3) begin
                case (col_idx)
                    0:       key_kind = KIND_STAR;
                    1:       key_kind = KIND_DIGIT;
                    2:       key_kind = KIND_HASH;
                    default: key_kind = KIND_INVALID;
                endcase
            end
        end
    end

    // Next-state logic. Key effects are computed first; any clear request
    // ('*', ops_ack in DONE, or the idle timeout) then overrides the operand
    // and state updates so a clear always wins over a simultaneous digit.
    always_comb begin
        state_d       = state_q;
        operand_a_d   = operand_a_q;
        operand_b_d   = operand_b_q;
        digit_count_d = digit_count_q;
        key_ack_d     = accept;
        key_err_d     = 1'b0;
        clear_req     = 1'b0;
`ifdef INPUT_TIMEOUT_EN
        idle_cnt_d    = '0;
        timeout_d     = 1'b0;
`endif

        if (accept) begin
            case (key_kind)
                KIND_STAR: clear_req = 1'b1;
                KIND_DIGIT: begin
                    if (state_q != ST_DONE) begin
                        if (digit_count_q < DC_W'(MAX_DIGITS)) begin
                            if (state_q == ST_ENTER_A)
                                operand_a_d = append_digit(operand_a_q, key_digit);
                            else
                                operand_b_d = append_digit(operand_b_q, key_digit);
                            digit_count_d = digit_count_q + 1'b1;
                        end else begin
                            key_err_d = 1'b1;
                        end
                    end
                end
                KIND_HASH: begin
                    if (state_q == ST_ENTER_A) begin
                        if (digit_count_q != '0) begin
                            state_d       = ST_ENTER_B;
                            digit_count_d = '0;
                        end else begin
                            key_err_d = 1'b1;
                        end
                    end else if (state_q == ST_ENTER_B) begin
                        if (digit_count_q != '0)
                            state_d = ST_DONE;
                        else
                            key_err_d = 1'b1;
                    end
                end
                default: key_err_d = 1'b1;
            endcase
        end

        if (state_q == ST_DONE && ops_ack)
            clear_req = 1'b1;

`ifdef INPUT_TIMEOUT_EN
        // The idle counter only runs while something partial has been
        // entered; an accepted key restarts it by leaving it at zero.
        if (state_q != ST_DONE && !accept &&
            (digit_count_q != '0 || state_q == ST_ENTER_B)) begin
            if (idle_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                clear_req = 1'b1;
                timeout_d = 1'b1;
            end else begin
                idle_cnt_d = idle_cnt_q + 1'b1;
            end
        end
`endif

        if (clear_req) begin
            state_d       = ST_ENTER_A;
            operand_a_d   = '0;
            operand_b_d   = '0;
            digit_count_d = '0;
        end
    end

    // Main state and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_ENTER_A;
            operand_a_q   <= '0;
            operand_b_q   <= '0;
            digit_count_q <= '0;
            key_ack_q     <= 1'b0;
            key_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            operand_a_q   <= operand_a_d;
            operand_b_q   <= operand_b_d;
            digit_count_q <= digit_count_d;
            key_ack_q     <= key_ack_d;
            key_err_q     <= key_err_d;
        end
    end

`ifdef INPUT_TIMEOUT_EN
    // Idle counter and timeout pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign key_ack     = key_ack_q;
    assign key_err     = key_err_q;
    assign operand_a   = operand_a_q;
    assign operand_b   = operand_b_q;
    assign digit_count = digit_count_q;
    // B stays flagged in DONE because the pair was completed from B entry.
    assign entering_b  = (state_q != ST_ENTER_A);
    assign ops_valid   = (state_q == ST_DONE);

endmodule
